// File: rtl/aibcr3aux_osc_div.sv
// Scannable programmable divider for the aux oscillator clock: a synchronised enable
// produces a glitch-free divided clock and a rise-aligned tick.
module aibcr3aux_osc_div #(
    parameter int CNT_W = 4
) (
    input  logic             cp,
    input  logic             cdn,
    inout  wire              vbb,
    inout  wire              vdd,
    inout  wire              vpp,
    inout  wire              vss,
    input  logic             en,
    input  logic [CNT_W-1:0] div_sel,
    input  logic             se_n,
    input  logic             si,
    output logic             clk_div,
    output logic             div_tick,
    output logic             so
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] STOP = 2'b10;

    logic             sync0;
    logic             sync1;
    logic [1:0]       state;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] counter;

    logic [1:0]       state_nx;
    logic [CNT_W-1:0] shadow_nx;
    logic [CNT_W-1:0] counter_nx;
    logic             clk_div_nx;
    logic             div_tick_nx;
    logic             en_s;
    logic             terminal;

    logic unused_supply;
    assign unused_supply = ^{vbb, vdd, vpp, vss};

    assign en_s     = sync1;
    assign terminal = (counter == shadow);
    assign so       = clk_div;

    // A high phase always runs to its terminal count before the divider stops.
    always_comb begin
        state_nx    = state;
        shadow_nx   = shadow;
        counter_nx  = counter;
        clk_div_nx  = clk_div;
        div_tick_nx = 1'b0;
        case (state)
            IDLE: begin
                counter_nx = '0;
                clk_div_nx = 1'b0;
                if (en_s) begin
                    shadow_nx = div_sel;
                    state_nx  = RUN;
                end
            end
            RUN: begin
                if (!en_s && !clk_div) begin
                    counter_nx = '0;
                    state_nx   = IDLE;
                end else if (terminal) begin
                    counter_nx = '0;
                    if (!en_s) begin
                        clk_div_nx = 1'b0;
                        state_nx   = IDLE;
                    end else begin
                        clk_div_nx  = ~clk_div;
                        div_tick_nx = ~clk_div;
                        shadow_nx   = div_sel;
                    end
                end else begin
                    counter_nx = counter + CNT_W'(1);
                    if (!en_s) begin
                        state_nx = STOP;
                    end
                end
            end
            STOP: begin
                if (terminal) begin
                    counter_nx = '0;
                    clk_div_nx = 1'b0;
                    state_nx   = IDLE;
                end else begin
                    counter_nx = counter + CNT_W'(1);
                end
            end
            default: begin
                counter_nx = '0;
                clk_div_nx = 1'b0;
                state_nx   = IDLE;
            end
        endcase
    end

    // Scan chain: si, sync0, sync1, state[0], state[1], shadow[0..], counter[0..], div_tick, clk_div.
    always_ff @(posedge cp or negedge cdn) begin
        if (!cdn) begin
            sync0    <= 1'b0;
            sync1    <= 1'b0;
            state    <= IDLE;
            shadow   <= '0;
            counter  <= '0;
            div_tick <= 1'b0;
            clk_div  <= 1'b0;
        end else if (!se_n) begin
            sync0    <= si;
            sync1    <= sync0;
            state    <= {state[0], sync1};
            shadow   <= {shadow[CNT_W-2:0], state[1]};
            counter  <= {counter[CNT_W-2:0], shadow[CNT_W-1]};
            div_tick <= counter[CNT_W-1];
            clk_div  <= div_tick;
        end else begin
            sync0    <= en;
            sync1    <= sync0;
            state    <= state_nx;
            shadow   <= shadow_nx;
            counter  <= counter_nx;
            div_tick <= div_tick_nx;
            clk_div  <= clk_div_nx;
        end
    end

endmodule

// File: tb/tb_aibcr3aux_osc_div.sv
// Directed bench for aibcr3aux_osc_div: expected waveforms are queued per cp cycle
// and compared one entry per rising edge.
module tb_aibcr3aux_osc_div;

    localparam int CNT_W = 4;

    logic             cp;
    logic             cdn;
    logic             en;
    logic [CNT_W-1:0] div_sel;
    logic             se_n;
    logic             si;
    logic             clk_div;
    logic             div_tick;
    logic             so;
    wire              vbb;
    wire              vdd;
    wire              vpp;
    wire              vss;

    assign vbb = 1'b0;
    assign vdd = 1'b1;
    assign vpp = 1'b1;
    assign vss = 1'b0;

    aibcr3aux_osc_div #(.CNT_W(CNT_W)) dut (
        .cp       (cp),
        .cdn      (cdn),
        .vbb      (vbb),
        .vdd      (vdd),
        .vpp      (vpp),
        .vss      (vss),
        .en       (en),
        .div_sel  (div_sel),
        .se_n     (se_n),
        .si       (si),
        .clk_div  (clk_div),
        .div_tick (div_tick),
        .so       (so)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    typedef struct {
        logic cd;
        logic tk;
        logic sv;
    } exp_t;

    exp_t        sb[$];
    int          compared = 0;
    int          mism     = 0;
    logic [13:0] pat      = 14'b10110011100101;

    task automatic cmp(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push(input logic cd, input logic tk, input logic sv, input int n);
        exp_t e;
        e.cd = cd;
        e.tk = tk;
        e.sv = sv;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic push_fn(input logic cd, input logic tk, input int n);
        push(cd, tk, cd, n);
    endtask

    task automatic run(input int n, input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge cp);
            #1;
            if (sb.size() == 0) begin
                cmp($sformatf("%s[%0d]/queue_empty", tag, i), 2'b01, 2'b00);
            end else begin
                e = sb.pop_front();
                cmp($sformatf("%s[%0d]/clk_div", tag, i), {1'b0, clk_div}, {1'b0, e.cd});
                cmp($sformatf("%s[%0d]/div_tick", tag, i), {1'b0, div_tick}, {1'b0, e.tk});
                cmp($sformatf("%s[%0d]/so", tag, i), {1'b0, so}, {1'b0, e.sv});
            end
        end
    endtask

    task automatic do_reset();
        en  = 1'b0;
        cdn = 1'b0;
        #2;
        cdn = 1'b1;
    endtask

    function automatic logic sbit(input int i);
        if (i >= 1 && i <= 14) return pat[14-i];
        return 1'b0;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cdn     = 1'b0;
        en      = 1'b0;
        div_sel = '0;
        se_n    = 1'b1;
        si      = 1'b0;
        #3;
        cmp("reset/clk_div", {1'b0, clk_div}, 2'b00);
        cmp("reset/div_tick", {1'b0, div_tick}, 2'b00);
        cmp("reset/so", {1'b0, so}, 2'b00);
        cmp("reset/state", dut.state, 2'b00);
        @(posedge cp);
        #1;
        cdn = 1'b1;

        // Enable with div_sel=2: first rise on the 6th edge, then period 6.
        div_sel = 4'd2;
        en      = 1'b1;
        push_fn(1'b0, 1'b0, 5);
        for (int p = 0; p < 3; p++) begin
            push_fn(1'b1, 1'b1, 1);
            push_fn(1'b1, 1'b0, 2);
            push_fn(1'b0, 1'b0, 3);
        end
        run(23, "enable");

        // Ratio change one cycle after a rise.
        do_reset();
        div_sel = 4'd1;
        en      = 1'b1;
        push_fn(1'b0, 1'b0, 4);
        push_fn(1'b1, 1'b1, 1);
        push_fn(1'b1, 1'b0, 1);
        run(6, "ratio_a");
        div_sel = 4'd3;
        push_fn(1'b0, 1'b0, 4);
        push_fn(1'b1, 1'b1, 1);
        push_fn(1'b1, 1'b0, 3);
        push_fn(1'b0, 1'b0, 4);
        run(12, "ratio_b");

        // Disable during the high phase.
        do_reset();
        div_sel = 4'd4;
        en      = 1'b1;
        push_fn(1'b0, 1'b0, 7);
        push_fn(1'b1, 1'b1, 1);
        push_fn(1'b1, 1'b0, 1);
        run(9, "dis_high_a");
        en = 1'b0;
        push_fn(1'b1, 1'b0, 3);
        push_fn(1'b0, 1'b0, 12);
        run(15, "dis_high_b");
        cmp("dis_high/state", dut.state, 2'b00);

        // Disable during the low phase.
        do_reset();
        div_sel = 4'd4;
        en      = 1'b1;
        push_fn(1'b0, 1'b0, 7);
        push_fn(1'b1, 1'b1, 1);
        push_fn(1'b1, 1'b0, 4);
        push_fn(1'b0, 1'b0, 1);
        run(13, "dis_low_a");
        en = 1'b0;
        push_fn(1'b0, 1'b0, 2);
        run(2, "dis_low_b");
        cmp("dis_low/state_run", dut.state, 2'b01);
        push_fn(1'b0, 1'b0, 1);
        run(1, "dis_low_c");
        cmp("dis_low/state_idle", dut.state, 2'b00);
        push_fn(1'b0, 1'b0, 10);
        run(10, "dis_low_d");

        // Scan shift of a 14-bit pattern through the whole chain.
        do_reset();
        se_n = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            si = sbit(k);
            push(sbit(k - 13), sbit(k - 12), sbit(k - 13), 1);
            run(1, $sformatf("scan%0d", k));
        end
        si = 1'b0;

        // Scan-load the illegal state code 11.
        do_reset();
        se_n = 1'b0;
        si = 1'b1; @(posedge cp); #1;
        si = 1'b1; @(posedge cp); #1;
        si = 1'b0; @(posedge cp); #1;
        si = 1'b0; @(posedge cp); #1;
        cmp("scan_load/state", dut.state, 2'b11);
        se_n = 1'b1;
        @(posedge cp);
        #1;
        cmp("illegal/state", dut.state, 2'b00);

        // Asynchronous clear during a high phase, then restart.
        do_reset();
        div_sel = 4'd2;
        en      = 1'b1;
        push_fn(1'b0, 1'b0, 5);
        push_fn(1'b1, 1'b1, 1);
        run(6, "areset_a");
        #2;
        cdn = 1'b0;
        #1;
        cmp("areset/clk_div", {1'b0, clk_div}, 2'b00);
        cmp("areset/div_tick", {1'b0, div_tick}, 2'b00);
        cmp("areset/so", {1'b0, so}, 2'b00);
        cdn = 1'b1;
        push_fn(1'b0, 1'b0, 5);
        push_fn(1'b1, 1'b1, 1);
        push_fn(1'b1, 1'b0, 2);
        push_fn(1'b0, 1'b0, 3);
        push_fn(1'b1, 1'b1, 1);
        run(12, "areset_b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule

// File: doc/aibcr3aux_osc_div.md
Name: aibcr3aux_osc_div

Overview:
- Scannable programmable divider directly downstream of the aux oscillator sampling flop; consumes the oscillator clock and produces a slow, glitch-free divided clock for aux housekeeping logic.
- Built entirely from scan flops: async active-low clear, mux-scan, chained through si/so.
- Enable is asynchronous to cp and synchronised internally.
- Divide ratio changes only at a phase boundary.

Parameters:
CNT_W, 4, width of divide-select and counter; divide ratio = 2*(div_sel+1), range 2..2^(CNT_W+1)

Ports:
cp  input  1  oscillator clock, rising-edge
cdn  input  1  asynchronous active-low clear of every flop
vbb  inout  1  body bias supply, no logical function
vdd  inout  1  core supply, no logical function
vpp  inout  1  high supply, no logical function
vss  inout  1  ground, no logical function
en  input  1  divider enable, asynchronous to cp
div_sel  input  CNT_W  terminal count; half-period = div_sel+1 cp cycles
se_n  input  1  scan enable, active-low (0 = shift)
si  input  1  scan input
clk_div  output  1  divided clock, registered
div_tick  output  1  one-cp-cycle pulse coincident with each clk_div rise
so  output  1  scan output (last chain flop)

Behaviour:
- Reset (cdn=0, asynchronous): all flops are cleared.
  - clk_div=0, div_tick=0, so=0, state=IDLE.
  - Counter=0, shadow=0, sync=00.
- Release of cdn is assumed synchronous to cp at system level.
- Synchroniser: en -> sync0 -> sync1 (en_s); 2-cp latency.
- States (2-bit encoding): IDLE=00, RUN=01, STOP=10. Code 11 is illegal and returns to IDLE on the next edge.
- IDLE:
  - Counter=0, clk_div=0.
  - If en_s=1: shadow<=div_sel, go to RUN.
- RUN: counter increments every cp. When counter==shadow (terminal):
  - counter<=0, clk_div<=~clk_div, shadow<=div_sel.
  - div_tick<=1 if clk_div goes 0->1, else 0.
  - At all other times div_tick<=0.
- RUN with en_s=0:
  - If clk_div=0: go to IDLE immediately; counter<=0.
  - If clk_div=1: go to STOP.
- STOP:
  - Keeps counting at the current shadow.
  - At terminal: clk_div<=0, counter<=0, go to IDLE.
  - en_s is ignored in STOP; re-enable takes effect from IDLE.
- Glitch-free guarantees:
  - The high phase is never truncated.
  - No clk_div pulse is shorter than (shadow+1) cp cycles.
- Ratio change: div_sel is sampled only at terminal or IDLE->RUN. Mid-phase changes do not affect the current half-period.
- First output edge: en rises, then after 2 cp (sync) + 1 cp (IDLE->RUN) + (div_sel+1) cp, clk_div rises.
- Terminal when counter > shadow is unreachable. If reached via scan load, the counter wraps through all-ones to 0, then normal operation resumes.
- Scan mode (se_n=0):
  - Every flop captures its chain predecessor; functional logic is frozen.
  - Chain order from si: sync0, sync1, state[0], state[1], shadow[0..CNT_W-1], counter[0..CNT_W-1], div_tick, clk_div -> so.
  - Chain length = 2*CNT_W+6 (14 at default).
- se_n=1: so still equals the clk_div flop output.
- cdn asserted mid-operation: outputs go to 0 immediately, regardless of phase.

Test Plan:
- Reset then enable:
  - Stimulus: cdn low, then high; div_sel=2; en=1.
  - Response: clk_div first rises 6 cp after en is sampled (2 sync + 1 + 3); then period = 6 cp, 50% duty; div_tick high exactly 1 cp at each rise.
- Ratio change mid-phase:
  - Stimulus: running with div_sel=1; change to 3 one cycle after a toggle.
  - Response: current half-period stays 2 cp; following half-periods are 4 cp; no short pulse.
- Disable in high phase:
  - Stimulus: div_sel=4; drop en 1 cp after clk_div rises.
  - Response: clk_div stays high the full 5 cp, falls, and stays 0 (IDLE).
- Disable in low phase:
  - Stimulus: drop en while clk_div=0.
  - Response: FSM is in IDLE 2 cp after en falls (+1 transition); clk_div never rises again.
- Scan shift:
  - Stimulus: se_n=0; shift 14-bit pattern 10110011100101.
  - Response: pattern emerges on so after 14 cp, unmodified.
  - Stimulus: load state=11.
  - Response: FSM returns to IDLE on the first functional cp.
- Async reset mid-run:
  - Stimulus: cdn pulsed low between cp edges while clk_div=1.
  - Response: clk_div, div_tick and so are 0 immediately; restart timing equals the first scenario.
